// File: rtl/bram_portb_arb.sv
// rtl/bram_portb_arb.sv - two-requester round-robin arbiter sharing BRAM Port-B
// Ports:
//   Clk, Reset              : clock, synchronous active-high reset
//   req/we/addr/din 0 and 1 : requester access (held until reqN && gntN)
//   gnt0, gnt1              : combinational grants, at most one high
//   rvalid0, rvalid1, rdata : read return, rdata shared and registered
//   web, addrb, dinb, doutb : Port-B drive and read data
//   busy                    : an accepted access is still in the pipeline
module bram_portb_arb #(
  parameter int P_MAX_BURST = 4,
  parameter int P_ADDR_W    = 9
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [3:0]          we0,
  input  logic [3:0]          we1,
  input  logic [P_ADDR_W-1:0] addr0,
  input  logic [P_ADDR_W-1:0] addr1,
  input  logic [31:0]         din0,
  input  logic [31:0]         din1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [31:0]         rdata,
  output logic [3:0]          web,
  output logic [P_ADDR_W-1:0] addrb,
  output logic [31:0]         dinb,
  input  logic [31:0]         doutb,
  output logic                busy
);

  localparam logic [7:0] MAX_B = 8'(P_MAX_BURST);

  logic                owner;
  logic [7:0]          burst_cnt;
  logic                both;
  logic                sel;
  logic                acc;
  logic                acc_id;

  logic                s1_valid;
  logic                s1_id;
  logic [3:0]          s1_we;
  logic [P_ADDR_W-1:0] s1_addr;
  logic [31:0]         s1_din;
  logic                s2_valid;
  logic                s2_id;

  // Under contention the owner keeps the port until it has used its burst
  // allowance; a lone requester is never throttled.
  always_comb begin
    both   = req0 & req1;
    sel    = (burst_cnt < MAX_B) ? owner : ~owner;
    gnt0   = both ? ~sel : req0;
    gnt1   = both ? sel : (req1 & ~req0);
    acc    = (req0 & gnt0) | (req1 & gnt1);
    acc_id = gnt1;
  end

  // Idle cycles keep owner and burst_cnt so a paused burst resumes its count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner     <= 1'b0;
      burst_cnt <= 8'd0;
    end else if (acc) begin
      if (acc_id == owner) begin
        if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
      end else begin
        owner     <= acc_id;
        burst_cnt <= 8'd1;
      end
    end
  end

  // S1 drives Port-B, S2 waits for doutb, S3 is the rdata/rvalid register.
  // s1_addr/s1_din only load on accept so addrb/dinb hold between accesses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_we    <= 4'b0000;
      s1_addr  <= '0;
      s1_din   <= 32'd0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_id   <= acc_id;
        s1_we   <= acc_id ? we1 : we0;
        s1_addr <= acc_id ? addr1 : addr0;
        s1_din  <= acc_id ? din1 : din0;
      end
      s2_valid <= s1_valid & (s1_we == 4'b0000);
      s2_id    <= s1_id;
      rvalid0  <= s2_valid & ~s2_id;
      rvalid1  <= s2_valid & s2_id;
      if (s2_valid) rdata <= doutb;
    end
  end

  assign web   = s1_valid ? s1_we : 4'b0000;
  assign addrb = s1_addr;
  assign dinb  = s1_din;
  assign busy  = s1_valid | s2_valid | rvalid0 | rvalid1;

endmodule

// File: tb/tb_bram_portb_arb.sv
// tb/tb_bram_portb_arb.sv - self-checking bench for bram_portb_arb (burst limits 4 and 1)
module tb_bram_portb_arb;

  typedef struct {
    int          dut;
    logic [3:0]  we;
    logic [8:0]  addr;
    logic [31:0] din;
    int          cyc;
  } pt_t;

  typedef struct {
    int          dut;
    int          id;
    logic [31:0] data;
    int          cyc;
  } rd_t;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] w0;
    logic [3:0] w1;
    logic [8:0] a0;
    logic [8:0] a1;
    logic [1:0] eg4;
    logic [1:0] eg1;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [3:0]  we0 = 4'h0;
  logic [3:0]  we1 = 4'h0;
  logic [8:0]  addr0 = 9'h0;
  logic [8:0]  addr1 = 9'h0;
  logic [31:0] din0 = 32'h0;
  logic [31:0] din1 = 32'h0;

  logic [1:0]  gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, busy_w;
  logic [31:0] rdata_w [2];
  logic [3:0]  web_w [2];
  logic [8:0]  addrb_w [2];
  logic [31:0] dinb_w [2];
  logic [31:0] doutb_w [2];

  logic [31:0] mem [2][512];
  logic [31:0] shadow [2][512];
  bit          loaded = 1'b0;

  pt_t  ptq[$];
  rd_t  rdq[$];
  vec_t tbl[16];
  int   ntests = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   port_acc[2];
  int   snap[2];

  always #5 Clk = ~Clk;

  bram_portb_arb #(.P_MAX_BURST(4), .P_ADDR_W(9)) dut4 (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]),
    .rvalid0(rvalid0_w[0]), .rvalid1(rvalid1_w[0]), .rdata(rdata_w[0]),
    .web(web_w[0]), .addrb(addrb_w[0]), .dinb(dinb_w[0]), .doutb(doutb_w[0]),
    .busy(busy_w[0])
  );

  bram_portb_arb #(.P_MAX_BURST(1), .P_ADDR_W(9)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]),
    .rvalid0(rvalid0_w[1]), .rvalid1(rvalid1_w[1]), .rdata(rdata_w[1]),
    .web(web_w[1]), .addrb(addrb_w[1]), .dinb(dinb_w[1]), .doutb(doutb_w[1]),
    .busy(busy_w[1])
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 32) return 32'h1122_3344;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Read-first synchronous Port-B memory, one per arbiter instance.
  always @(posedge Clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) begin
        mem[0][i] = init_val(i);
        mem[1][i] = init_val(i);
      end
      loaded = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      doutb_w[d] <= mem[d][addrb_w[d]];
      for (int b = 0; b < 4; b++)
        if (web_w[d][b] === 1'b1) mem[d][addrb_w[d]][8*b +: 8] = dinb_w[d][8*b +: 8];
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int d);
    ntests++;
    nfail++;
    $display("FAIL %s dut%0d (cycle %0d)", nm, d, cyc);
  endtask

  function automatic int find_pt(input int d);
    foreach (ptq[i]) if (ptq[i].dut == d) return i;
    return -1;
  endfunction

  function automatic int find_rd(input int d);
    foreach (rdq[i]) if (rdq[i].dut == d) return i;
    return -1;
  endfunction

  // Scoreboard push at the accept decision: Port-B drive expected next
  // cycle, read data expected three cycles later.
  task automatic record(input int d);
    int k;
    pt_t pe;
    rd_t re;
    chk("gnt_onehot", d, 32'(gnt0_w[d] & gnt1_w[d]), 32'd0);
    k = -1;
    if (req0 && gnt0_w[d]) k = 0;
    else if (req1 && gnt1_w[d]) k = 1;
    if (k >= 0) begin
      pe.dut  = d;
      pe.we   = (k == 1) ? we1 : we0;
      pe.addr = (k == 1) ? addr1 : addr0;
      pe.din  = (k == 1) ? din1 : din0;
      pe.cyc  = cyc;
      ptq.push_back(pe);
      if (pe.we == 4'h0) begin
        re.dut  = d;
        re.id   = k;
        re.data = shadow[d][pe.addr];
        re.cyc  = cyc;
        rdq.push_back(re);
      end else begin
        for (int b = 0; b < 4; b++)
          if (pe.we[b]) shadow[d][pe.addr][8*b +: 8] = pe.din[8*b +: 8];
      end
    end
  endtask

  task automatic monitor(input int d);
    int  pi;
    int  ri;
    logic eb;
    pi = find_pt(d);
    ri = find_rd(d);
    eb = 1'b0;
    if (pi >= 0 && ptq[pi].cyc + 1 == cyc) eb = 1'b1;
    foreach (rdq[i])
      if (rdq[i].dut == d && (rdq[i].cyc + 2 == cyc || rdq[i].cyc + 3 == cyc)) eb = 1'b1;
    chk("busy", d, 32'(busy_w[d]), 32'(eb));
    if (pi >= 0 && ptq[pi].cyc + 1 == cyc) begin
      chk("web", d, 32'(web_w[d]), 32'(ptq[pi].we));
      chk("addrb", d, 32'(addrb_w[d]), 32'(ptq[pi].addr));
      chk("dinb", d, dinb_w[d], ptq[pi].din);
      port_acc[d]++;
      ptq.delete(pi);
    end else begin
      chk("web_idle", d, 32'(web_w[d]), 32'd0);
    end
    if (rvalid0_w[d] || rvalid1_w[d]) begin
      chk("rvalid_onehot", d, 32'(rvalid0_w[d] & rvalid1_w[d]), 32'd0);
      if (ri < 0) begin
        fail_now("unexpected_rvalid", d);
      end else begin
        chk("rvalid_id", d, 32'(rvalid1_w[d]), 32'(rdq[ri].id));
        chk("rdata", d, rdata_w[d], rdq[ri].data);
        chk("read_latency", d, 32'(cyc), 32'(rdq[ri].cyc + 3));
        rdq.delete(ri);
      end
    end else if (ri >= 0 && rdq[ri].cyc + 3 <= cyc) begin
      fail_now("missing_rvalid", d);
      rdq.delete(ri);
    end
  endtask

  // One clock cycle: drive at +2, decide accepts at +4, check at the falling edge.
  task automatic step(input logic rst, input logic r0, input logic r1,
                      input logic [3:0] w0, input logic [3:0] w1,
                      input logic [8:0] a0, input logic [8:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(posedge Clk);
    cyc++;
    #2;
    Reset = rst; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; din0 = d0; din1 = d1;
    #2;
    if (!rst) for (int d = 0; d < 2; d++) record(d);
    @(negedge Clk);
    for (int d = 0; d < 2; d++) monitor(d);
    if (rst) rdq.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    port_acc[0] = 0;
    port_acc[1] = 0;
    for (int i = 0; i < 512; i++) begin
      shadow[0][i] = init_val(i);
      shadow[1][i] = init_val(i);
    end
    // Both requesting: requester 0 reads 0x100+i, requester 1 advances its
    // address every two cycles so the alternating instance reads 0..7.
    for (int i = 0; i < 16; i++) begin
      tbl[i].r0  = 1'b1;
      tbl[i].r1  = 1'b1;
      tbl[i].w0  = 4'h0;
      tbl[i].w1  = 4'h0;
      tbl[i].a0  = 9'(9'h100 + i);
      tbl[i].a1  = 9'(i / 2);
      tbl[i].eg4 = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
      tbl[i].eg1 = (i % 2 == 1) ? 2'b10 : 2'b01;
    end

    repeat (3) step(1'b1, '0, '0, '0, '0, '0, '0, '0, '0);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      chk("rst_web", d, 32'(web_w[d]), 32'd0);
      chk("rst_addrb", d, 32'(addrb_w[d]), 32'd0);
      chk("rst_dinb", d, dinb_w[d], 32'd0);
      chk("rst_rdata", d, rdata_w[d], 32'd0);
      chk("rst_rvalid", d, 32'({rvalid1_w[d], rvalid0_w[d]}), 32'd0);
      chk("rst_busy", d, 32'(busy_w[d]), 32'd0);
      chk("rst_gnt", d, 32'({gnt1_w[d], gnt0_w[d]}), 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b0, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1, 32'h0, 32'h0);
      chk("contend_gnt_max4", 0, 32'({gnt1_w[0], gnt0_w[0]}), 32'(tbl[i].eg4));
      chk("contend_gnt_max1", 1, 32'({gnt1_w[1], gnt0_w[1]}), 32'(tbl[i].eg1));
    end
    idle(5);

    // Write then immediately read the same word from the other requester.
    step(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 9'h005, 9'h000, 32'hDEAD_BEEF, 32'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 9'h000, 9'h005, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) chk("single_gnt1", d, 32'({gnt1_w[d], gnt0_w[d]}), 32'd2);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      chk("single_addrb", d, 32'(addrb_w[d]), 32'h005);
      chk("single_web", d, 32'(web_w[d]), 32'd0);
    end
    idle(2);
    for (int d = 0; d < 2; d++) begin
      chk("single_rvalid", d, 32'({rvalid1_w[d], rvalid0_w[d]}), 32'd2);
      chk("single_rdata", d, rdata_w[d], 32'hDEAD_BEEF);
    end
    idle(3);

    // Partial byte write over the preloaded word at 0x20.
    step(1'b0, 1'b1, 1'b0, 4'b0101, 4'h0, 9'h020, 9'h000, 32'hAABB_CCDD, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 9'h020, 9'h000, 32'h0, 32'h0);
    idle(3);
    for (int d = 0; d < 2; d++) chk("byte_en_rdata", d, rdata_w[d], 32'h11BB_33DD);
    idle(2);

    // Reset one cycle after a requester 1 read is accepted.
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 9'h000, 9'h003, 32'h0, 32'h0);
    step(1'b1, '0, '0, '0, '0, '0, '0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 9'h006, 9'h007, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk("midrst_rvalid", d, 32'({rvalid1_w[d], rvalid0_w[d]}), 32'd0);
      chk("midrst_web", d, 32'(web_w[d]), 32'd0);
      chk("midrst_busy", d, 32'(busy_w[d]), 32'd0);
      chk("midrst_rdata", d, rdata_w[d], 32'd0);
      chk("midrst_tie_gnt", d, 32'({gnt1_w[d], gnt0_w[d]}), 32'd1);
    end
    idle(5);

    // Lone requester well past the burst limit.
    snap[0] = port_acc[0];
    snap[1] = port_acc[1];
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 9'(9'h040 + i), 9'h000, $urandom, 32'h0);
      for (int d = 0; d < 2; d++) chk("lone_gnt0", d, 32'(gnt0_w[d]), 32'd1);
    end
    idle(3);
    for (int d = 0; d < 2; d++) chk("lone_port_accesses", d, 32'(port_acc[d] - snap[d]), 32'd10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 9'h000, 9'(9'h040 + 3 * i), 32'h0, 32'h0);
    idle(6);

    chk("rd_queue_drained", 0, 32'(rdq.size()), 32'd0);
    chk("port_queue_drained", 0, 32'(ptq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
